// File: rtl/tff_bank_toggle_arbiter_pkg.sv
// rtl/tff_bank_toggle_arbiter_pkg.sv - shared definitions for the TFF bank toggle arbiter
//   Contents: arbiter FSM state encoding and a width helper for pointer/counter sizing.
package tff_arb_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    COOL  = 2'd2
  } arb_state_t;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/tff_bank_toggle_arbiter_cell.sv
// rtl/tff_bank_toggle_arbiter_cell.sv - single T flip-flop of the shared bank
//   Ports: clk   rising-edge clock
//          reset synchronous active-high clear to 0
//          t     toggle enable for this cycle
//          q     stored bit
module tff_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      q <= q ^ t;
    end
  end

endmodule

// File: rtl/tff_bank_toggle_arbiter.sv
// rtl/tff_bank_toggle_arbiter.sv - round-robin arbiter applying one toggle mask per grant to a TFF bank
//   Ports: clk   rising-edge clock
//          reset synchronous active-high, overrides everything
//          req   per-requester level request, held until granted
//          mask  requester i toggle mask at mask[i*WIDTH +: WIDTH]
//          gnt   one-hot grant, high only during the single apply cycle
//          busy  high whenever the arbiter is not idle
//          q     current TFF bank state
module tff_bank_toggle_arbiter
  import tff_arb_defs::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int COOLDOWN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] mask,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH-1:0]      q
);

  localparam int PTR_W = clog2_min1(NREQ);
  localparam int CNT_W = clog2_min1(COOLDOWN + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = (COOLDOWN > 0) ? CNT_W'(COOLDOWN - 1) : '0;

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  ptr_next;
  logic [PTR_W-1:0]  sel_q;
  logic [PTR_W-1:0]  pick_idx;
  logic [PTR_W-1:0]  cand;
  logic [PTR_W:0]    cand_sum;
  logic              pick_valid;
  logic [WIDTH-1:0]  mask_lat_q;
  logic [WIDTH-1:0]  t_vec;
  logic [CNT_W-1:0]  cnt_q;

  // Round-robin search: first asserted request at or after ptr_q, wrapping.
  // The sum is one bit wider so the wrap is a single conditional subtract.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand_sum   = '0;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_sum = {1'b0, ptr_q} + (PTR_W + 1)'(k);
      if (cand_sum >= (PTR_W + 1)'(NREQ)) begin
        cand_sum = cand_sum - (PTR_W + 1)'(NREQ);
      end
      cand = cand_sum[PTR_W-1:0];
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign ptr_next = (sel_q == PTR_W'(NREQ - 1)) ? '0 : sel_q + 1'b1;

  // State register plus the datapath registers that move with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      mask_lat_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            sel_q      <= pick_idx;
            mask_lat_q <= mask[int'(pick_idx)*WIDTH +: WIDTH];
          end
        end
        APPLY: begin
          ptr_q <= ptr_next;
          cnt_q <= CNT_LOAD;
        end
        COOL: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = APPLY;
      APPLY:   state_d = (COOLDOWN > 0) ? COOL : IDLE;
      COOL:    if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode purely from registered state, so gnt and the T inputs
  // never react combinationally to req/mask.
  always_comb begin
    gnt   = '0;
    t_vec = '0;
    busy  = (state_q != IDLE);
    if (state_q == APPLY) begin
      gnt   = {{(NREQ-1){1'b0}}, 1'b1} << sel_q;
      t_vec = mask_lat_q;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    tff_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .t     (t_vec[i]),
      .q     (q[i])
    );
  end

endmodule

// File: tb/tb_tff_bank_toggle_arbiter.sv
// tb/tb_tff_bank_toggle_arbiter.sv - self-checking bench for tff_bank_toggle_arbiter
module tb_tff_bank_toggle_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] mask;
  logic [NREQ-1:0]       gnt_a, gnt_b;
  logic                  busy_a, busy_b;
  logic [WIDTH-1:0]      q_a, q_b;

  int checks = 0;
  int errors = 0;

  // Instance a: cooldown of one cycle; instance b: no cooldown.
  tff_bank_toggle_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .COOLDOWN(1)) dut_a (
    .clk (clk), .reset (reset), .req (req), .mask (mask),
    .gnt (gnt_a), .busy (busy_a), .q (q_a)
  );

  tff_bank_toggle_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .COOLDOWN(0)) dut_b (
    .clk (clk), .reset (reset), .req (req), .mask (mask),
    .gnt (gnt_b), .busy (busy_b), .q (q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: grant = index being applied this cycle (-1 if none),
  // wait_n = idle cycles still owed before requests are looked at again.
  typedef struct {
    int             grant;
    int             wait_n;
    int             ptr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] pm;
  } mstate_t;

  mstate_t ms_a, ms_b;

  function automatic mstate_t model_next(input mstate_t s, input int cd, input logic rst,
                                         input logic [NREQ-1:0] r,
                                         input logic [NREQ*WIDTH-1:0] mk);
    mstate_t n;
    int c;
    n = s;
    if (rst) begin
      n.grant = -1; n.wait_n = 0; n.ptr = 0; n.q = '0; n.pm = '0;
    end else if (s.grant >= 0) begin
      n.q      = s.q ^ s.pm;
      n.ptr    = (s.grant + 1) % NREQ;
      n.grant  = -1;
      n.wait_n = cd;
    end else if (s.wait_n > 0) begin
      n.wait_n = s.wait_n - 1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        c = (s.ptr + k) % NREQ;
        if (n.grant < 0 && r[c]) begin
          n.grant = c;
          n.pm    = mk[c*WIDTH +: WIDTH];
        end
      end
    end
    return n;
  endfunction

  function automatic logic [NREQ-1:0] exp_gnt(input mstate_t s);
    logic [NREQ-1:0] one;
    one = 1;
    return (s.grant >= 0) ? (one << s.grant) : '0;
  endfunction

  function automatic logic exp_busy(input mstate_t s);
    return (s.grant >= 0) || (s.wait_n > 0);
  endfunction

  always @(posedge clk) begin
    ms_a <= model_next(ms_a, 1, reset, req, mask);
    ms_b <= model_next(ms_b, 0, reset, req, mask);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("a_gnt_model",  32'(gnt_a),  32'(exp_gnt(ms_a)));
    chk("a_busy_model", 32'(busy_a), 32'(exp_busy(ms_a)));
    chk("a_q_model",    32'(q_a),    32'(ms_a.q));
    chk("b_gnt_model",  32'(gnt_b),  32'(exp_gnt(ms_b)));
    chk("b_busy_model", 32'(busy_b), 32'(exp_busy(ms_b)));
    chk("b_q_model",    32'(q_b),    32'(ms_b.q));
  endtask

  // Inputs change on the falling edge; outputs are checked there too.
  task automatic step();
    @(negedge clk);
    cmp_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  logic [WIDTH-1:0] expq3 [5];

  initial begin
    expq3[0] = 8'h01; expq3[1] = 8'h03; expq3[2] = 8'h07; expq3[3] = 8'h0F; expq3[4] = 8'h0E;
    reset = 1'b1;
    req   = '0;
    mask  = '0;

    // 1: reset state
    step();
    step();
    chk("t1_q",    32'(q_a),    32'h00);
    chk("t1_gnt",  32'(gnt_a),  32'h0);
    chk("t1_busy", 32'(busy_a), 32'h0);
    reset = 1'b0;

    // 2: single request; mask change after sampling must be ignored
    req = 4'b0001;
    mask[0 +: WIDTH] = 8'hA5;
    step();
    chk("t2_gnt_apply",  32'(gnt_a),  32'h1);
    chk("t2_busy_apply", 32'(busy_a), 32'h1);
    chk("t2_q_apply",    32'(q_a),    32'h00);
    req = 4'b0000;
    mask[0 +: WIDTH] = 8'hFF;
    step();
    chk("t2_gnt_cool",  32'(gnt_a),  32'h0);
    chk("t2_busy_cool", 32'(busy_a), 32'h1);
    chk("t2_q_new",     32'(q_a),    32'hA5);
    chk("t2_model_q",   32'(ms_a.q), 32'hA5);
    step();
    chk("t2_busy_idle", 32'(busy_a), 32'h0);

    // 3: all requesting, round-robin order and spacing
    do_reset();
    mask = {8'h08, 8'h04, 8'h02, 8'h01};
    req  = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("t3_gnt", 32'(gnt_a), 32'(4'b0001 << (n % 4)));
      step();
      chk("t3_q", 32'(q_a), 32'(expq3[n]));
      step();
    end
    req = 4'b0000;
    step();

    // 4: no cooldown, held request, toggle every second cycle
    do_reset();
    mask = '0;
    mask[2*WIDTH +: WIDTH] = 8'hFF;
    req = 4'b0100;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("t4_gnt", 32'(gnt_b), (i % 2 == 1) ? 32'h4 : 32'h0);
      chk("t4_q",   32'(q_b),   (((i / 2) % 2) == 1) ? 32'hFF : 32'h00);
    end
    req = 4'b0000;
    step();

    // 5: reset during the apply cycle discards the toggle and the pointer move
    do_reset();
    mask = '0;
    mask[0 +: WIDTH] = 8'h3C;
    req = 4'b0001;
    step();
    chk("t5_gnt_apply", 32'(gnt_a), 32'h1);
    reset = 1'b1;
    step();
    chk("t5_q",    32'(q_a),    32'h00);
    chk("t5_gnt",  32'(gnt_a),  32'h0);
    chk("t5_busy", 32'(busy_a), 32'h0);
    reset = 1'b0;
    req = 4'b1111;
    step();
    chk("t5_ptr_zero", 32'(gnt_a), 32'h1);
    req = 4'b0000;
    step();
    step();

    // 6: zero mask still grants and advances the pointer; wrap to requester 0
    do_reset();
    mask = '0;
    mask[0 +: WIDTH] = 8'h11;
    req = 4'b0010;
    step();
    chk("t6_gnt1", 32'(gnt_a), 32'h2);
    req = 4'b0000;
    step();
    chk("t6_q_unchanged", 32'(q_a), 32'h00);
    step();
    req = 4'b0011;
    step();
    chk("t6_gnt_wrap", 32'(gnt_a), 32'h1);
    req = 4'b0000;
    step();
    chk("t6_q_after", 32'(q_a), 32'h11);
    chk("t6_model_q", 32'(ms_a.q), 32'h11);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
